alu_writeback: RTL

- Downstream stage of the complex ALU in each PE.
- Tracks every issued instruction through the ALU's fixed pipeline latency and pairs it with the ALU's 32-bit {I[31:16], Q[15:0]} result.
- Performs running MAX reduction across a vector.
- Buffers results in a small FIFO and drives a valid/ready write port toward the PE register file.
- Issues credit-based back-pressure so that no result is ever lost.

---
 rtl/alu_writeback.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Writeback stage behind the fixed-latency complex ALU: tags each issue, pairs it
// with the ALU result, reduces MAX vectors and queues register-file writes under credit control.
module alu_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int LATENCY    = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [2:0]              issue_opcode,
    input  logic [ADDR_WIDTH-1:0]   issue_waddr,
    input  logic                    issue_last,
    input  logic [DATA_WIDTH*2-1:0] alu_dout,
    output logic                    issue_stall,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [DATA_WIDTH*2-1:0] wb_data,
    output logic                    busy,
    output logic                    overflow_err
);

    localparam int WW = DATA_WIDTH * 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        OP_NOP0   = 3'b000,
        OP_NOP1   = 3'b001,
        OP_NOP2   = 3'b010,
        OP_NOP3   = 3'b011,
        OP_MUL    = 3'b100,
        OP_MULADD = 3'b101,
        OP_MULSUB = 3'b110,
        OP_MAX    = 3'b111
    } op_e;

    typedef struct packed {
        logic                  v;
        op_e                   op;
        logic [ADDR_WIDTH-1:0] waddr;
        logic                  last;
    } tag_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] waddr;
        logic [WW-1:0]         data;
    } entry_t;

    // A tag produces a register-file write for MUL-type ops and for the closing MAX element.
    function automatic logic writes_back(input op_e op, input logic last);
        return (op == OP_MUL) || (op == OP_MULADD) || (op == OP_MULSUB) ||
               ((op == OP_MAX) && last);
    endfunction

    tag_t          tag_pipe [LATENCY];
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count, inflight;
    logic          max_open;
    logic [WW-1:0] max_acc;

    tag_t          fin;
    entry_t        head;
    logic          issue_accept, issue_credit, retire_push;
    logic          fifo_full, pop, push_ok, any_tag;
    logic [WW-1:0] max_sel, push_data;
    logic [CW:0]   credit_used;

    assign fin          = tag_pipe[LATENCY-1];
    assign issue_accept = issue_valid & ~issue_stall;
    assign issue_credit = issue_accept & writes_back(op_e'(issue_opcode), issue_last);
    assign retire_push  = fin.v & writes_back(fin.op, fin.last);

    // Running maximum including the element arriving now; ties keep the accumulator.
    assign max_sel   = (max_open && ($signed(alu_dout) <= $signed(max_acc))) ? max_acc : alu_dout;
    assign push_data = (fin.op == OP_MAX) ? max_sel : alu_dout;

    assign fifo_full = (fifo_count == DEPTH_CNT);
    assign pop       = wb_valid & wb_ready;
    assign push_ok   = retire_push & (~fifo_full | pop);

    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue_stall = (credit_used >= DEPTH_SUM);

    assign head     = fifo_mem[rd_ptr];
    assign wb_valid = (fifo_count != '0);
    assign wb_addr  = wb_valid ? head.waddr : '0;
    assign wb_data  = wb_valid ? head.data  : '0;

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_tag = any_tag | tag_pipe[i].v;
        end
    end

    assign busy = any_tag | wb_valid | max_open;

    // NOTE: all state updates use <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{v: issue_accept, op: op_e'(issue_opcode),
                             waddr: issue_waddr, last: issue_last};
            for (int i = 1; i < LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_open <= 1'b0;
            max_acc  <= '0;
        end else if (fin.v && (fin.op == OP_MAX)) begin
            if (fin.last) begin
                max_open <= 1'b0;
            end else begin
                max_open <= 1'b1;
                max_acc  <= max_sel;
            end
        end
    end

    // NOTE: storage is not reset; the read side is gated by wb_valid, so stale entries never leak out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= '{waddr: fin.waddr, data: push_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + CNT_ONE;
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - CNT_ONE;
            end
            if (retire_push && fifo_full && !pop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Credits cover writes still inside the ALU pipe; the FIFO count covers the rest.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else if (issue_credit && !retire_push) begin
            inflight <= inflight + CNT_ONE;
        end else if (retire_push && !issue_credit) begin
            inflight <= inflight - CNT_ONE;
        end
    end

endmodule
